// File: rtl/rgmii_inband_status_mc.sv
// Multi-channel RGMII in-band status decoder: samples the inter-frame-gap status byte,
// validates it, filters over FILTER_N consecutive decodes and publishes link/duplex/speed.
module rgmii_inband_status_mc #(
  parameter int unsigned CH        = 2,
  parameter int unsigned GAP_W     = 5,
  parameter int unsigned SAMPLE_AT = 7,
  parameter int unsigned FILTER_N  = 3
) (
  input  logic              clk375,
  input  logic              rst,
  input  logic [CH-1:0]     val_in,
  input  logic [8*CH-1:0]   data_in,
  input  logic [CH-1:0]     clk125_on,
  output logic [CH-1:0]     link_up,
  output logic [CH-1:0]     duplex,
  output logic [2*CH-1:0]   speed,
  output logic [CH-1:0]     status_chg,
  output logic [CH-1:0]     status_err
);

  localparam int unsigned MW = 4;
  localparam logic [GAP_W-1:0] SAMPLE_CNT = GAP_W'(SAMPLE_AT);
  localparam logic [MW-1:0]    FILT       = MW'(FILTER_N);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [GAP_W-1:0] cnt;
    logic [7:0]       byte_reg;
    logic             smp_vld;
    logic [MW-1:0]    match_cnt;
    logic [3:0]       cand_last;
    logic [3:0]       status_q;   // {link, duplex, speed[1], speed[0]}
    logic             chg_q;
    logic             err_q;

    logic             evaluate_c;
    logic [3:0]       cand_c;
    logic             reject_c;
    logic [MW-1:0]    match_nxt_c;

    // Decode and validate the captured byte; 1000M needs the 125 MHz clock flag.
    always_comb begin
      evaluate_c  = !val_in[c] && (cnt == '0) && smp_vld;
      cand_c      = {byte_reg[0] & byte_reg[4],
                     byte_reg[3] & byte_reg[7],
                     byte_reg[2] & byte_reg[6] & clk125_on[c],
                     byte_reg[1] & byte_reg[5]};
      reject_c    = (byte_reg[3:0] != byte_reg[7:4]) || (cand_c[1:0] == 2'b11);
      match_nxt_c = MW'(1);
      if (cand_c == cand_last) begin
        match_nxt_c = (match_cnt >= FILT) ? FILT : match_cnt + MW'(1);
      end
    end

    always_ff @(posedge clk375) begin
      if (rst) begin
        cnt       <= '1;
        byte_reg  <= '0;
        smp_vld   <= 1'b0;
        match_cnt <= '0;
        cand_last <= '0;
        status_q  <= '0;
        chg_q     <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        chg_q <= 1'b0;
        err_q <= 1'b0;
        if (val_in[c]) begin
          cnt     <= '1;
          smp_vld <= 1'b0;
        end else begin
          cnt <= cnt - GAP_W'(1);
          if (cnt == SAMPLE_CNT) begin
            byte_reg <= data_in[8*c +: 8];
            smp_vld  <= 1'b1;
          end
          if (evaluate_c) begin
            smp_vld <= 1'b0;
            if (reject_c) begin
              err_q <= 1'b1;
            end else begin
              cand_last <= cand_c;
              match_cnt <= match_nxt_c;
              if (match_nxt_c == FILT && cand_c != status_q) begin
                status_q <= cand_c;
                chg_q    <= 1'b1;
              end
            end
          end
        end
      end
    end

    assign link_up[c]      = status_q[3];
    assign duplex[c]       = status_q[2];
    assign speed[2*c +: 2] = status_q[1:0];
    assign status_chg[c]   = chg_q;
    assign status_err[c]   = err_q;
  end

endmodule
